// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division, one bit per cycle.
// The sign correction for signed operations is applied in a single FIX cycle.
// MTHI/MTLO write HI/LO directly when the unit is idle.
module muldiv_sequencer #(
    parameter int WIDTH          = 32,
    parameter bit EARLY_MUL_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;     // product, or {remainder, quotient}
    logic [WIDTH-1:0]     opnd_q, opnd_d;   // multiplicand or divisor magnitude
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;  // negate product / quotient
    logic                 neg_rem_q, neg_rem_d;  // negate remainder
    logic                 dbz_pend_q, dbz_pend_d;
    logic                 dbz_q, dbz_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    // Operand magnitudes and one iteration of each datapath
    logic                 signed_op, rs_neg, rt_neg, accept, reserved;
    logic [WIDTH-1:0]     rs_mag, rt_mag;
    logic [WIDTH:0]       mul_sum, div_trial;
    logic [2*WIDTH-1:0]   mul_next, div_next, prod_neg;
    logic [WIDTH-1:0]     quot, rem;

    assign reserved  = op[2] & op[1];
    assign accept    = start && (state_q == S_IDLE) && !reserved;
    assign signed_op = ~op[0];
    assign rs_neg    = signed_op & rs_data[WIDTH-1];
    assign rt_neg    = signed_op & rt_data[WIDTH-1];
    assign rs_mag    = rs_neg ? -rs_data : rs_data;
    assign rt_mag    = rt_neg ? -rt_data : rt_data;

    // Shift-add step: conditionally add multiplicand to the upper half, shift right
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring step: trial-subtract divisor from the shifted partial remainder
    assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
    assign div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    assign quot      = acc_q[WIDTH-1:0];
    assign rem       = acc_q[2*WIDTH-1:WIDTH];
    assign prod_neg  = -acc_q;

    // Next-state and datapath updates; everything holds unless a state says otherwise
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        dbz_pend_d = dbz_pend_q;
        dbz_d      = dbz_q;
        done_d     = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    dbz_d      = 1'b0;
                    cnt_d      = CW'(WIDTH - 1);
                    neg_res_d  = rs_neg ^ rt_neg;
                    neg_rem_d  = 1'b0;
                    dbz_pend_d = 1'b0;
                    is_div_d   = op[1];
                    if (op[2]) begin
                        // MTHI / MTLO: direct write, unit stays idle
                        if (op[0]) lo_d = rs_data;
                        else       hi_d = rs_data;
                    end else if (!op[1]) begin
                        if (EARLY_MUL_ZERO && (rs_data == '0 || rt_data == '0)) begin
                            acc_d     = '0;
                            neg_res_d = 1'b0;
                            state_d   = S_FIX;
                        end else begin
                            acc_d   = {{WIDTH{1'b0}}, rt_mag};
                            opnd_d  = rs_mag;
                            state_d = S_CALC;
                        end
                    end else begin
                        if (rt_data == '0) begin
                            // Divide by zero: remainder=dividend, quotient=all-ones, no correction
                            acc_d      = {rs_data, {WIDTH{1'b1}}};
                            neg_res_d  = 1'b0;
                            dbz_pend_d = 1'b1;
                            state_d    = S_FIX;
                        end else begin
                            acc_d     = {{WIDTH{1'b0}}, rs_mag};
                            opnd_d    = rt_mag;
                            neg_rem_d = rs_neg;
                            state_d   = S_CALC;
                        end
                    end
                end
            end
            S_CALC: begin
                acc_d = is_div_q ? div_next : mul_next;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div_q) begin
                    lo_d = neg_res_q ? -quot : quot;
                    hi_d = neg_rem_q ? -rem : rem;
                end else begin
                    {hi_d, lo_d} = neg_res_q ? prod_neg : acc_q;
                end
                done_d  = 1'b1;
                dbz_d   = dbz_pend_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register with synchronous reset; an in-flight operation is simply dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_pend_q <= 1'b0;
            dbz_q      <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            dbz_pend_q <= dbz_pend_d;
            dbz_q      <= dbz_d;
            done_q     <= done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign stall       = start & busy;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer with hand-computed results.
module tb_muldiv_sequencer;
    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_RSVD  = 3'b110;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs, rt;
    logic        busy, stall, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_vec = 0;
    int n_err = 0;

    muldiv_sequencer #(.WIDTH(32), .EARLY_MUL_ZERO(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .rs_data     (rs),
        .rt_data     (rt),
        .busy        (busy),
        .stall       (stall),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Issue one MULT/DIV, scramble the operand inputs after accept, wait for done
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int elat, input logic edbz);
        int lat;
        int bcnt;
        bit seen;
        @(negedge clk);
        start = 1'b1; op = o; rs = a; rt = b;
        @(negedge clk);
        start = 1'b0; rs = $urandom; rt = $urandom;
        lat = 0; bcnt = 0; seen = 1'b0;
        for (int k = 1; k <= 100 && !seen; k++) begin
            if (k > 1) @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        check({tag, " latency"}, 64'(lat), 64'(elat));
        check({tag, " busy cycles"}, 64'(bcnt), 64'(elat - 1));
        check({tag, " hi"}, 64'(hi), 64'(ehi));
        check({tag, " lo"}, 64'(lo), 64'(elo));
        check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(edbz));
        @(negedge clk);
        check({tag, " done one-shot"}, 64'(done), 64'd0);
    endtask

    initial begin
        int dcnt;
        bit seen;
        rst = 1'b1; start = 1'b0; op = 3'b000; rs = '0; rt = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset dbz", 64'(div_by_zero), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset stall", 64'(stall), 64'd0);

        // Direct writes
        start = 1'b1; op = OP_MTHI; rs = 32'hCAFE_0001;
        @(negedge clk);
        op = OP_MTLO; rs = 32'h0BAD_F00D;
        check("mthi hi", 64'(hi), 64'hCAFE_0001);
        check("mthi no busy", 64'(busy), 64'd0);
        @(negedge clk);
        op = OP_RSVD; rs = 32'h5555_5555; rt = 32'h1;
        check("mtlo lo", 64'(lo), 64'h0BAD_F00D);
        check("reserved stall", 64'(stall), 64'd0);
        @(negedge clk);
        start = 1'b0;
        check("reserved busy", 64'(busy), 64'd0);
        check("reserved hi", 64'(hi), 64'hCAFE_0001);
        check("reserved lo", 64'(lo), 64'h0BAD_F00D);

        run_op("mult -3*7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34, 1'b0);
        run_op("multu ff*ff", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 34, 1'b0);
        run_op("mult -1*-1", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 34, 1'b0);
        run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 1'b0);
        run_op("divu 7/2", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 34, 1'b0);
        run_op("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 34, 1'b0);
        run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 34, 1'b0);
        run_op("div 5/0", OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 2, 1'b1);
        run_op("mult 6*-5", OP_MULT, 32'd6, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFE2, 34, 1'b0);
        run_op("mult 0*-9", OP_MULT, 32'd0, 32'hFFFF_FFF7, 32'h0, 32'h0, 2, 1'b0);

        // MTHI held while a MULT runs: stalls each busy cycle, accepted in the done cycle
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; rs = 32'd3; rt = 32'd5;
        @(negedge clk);
        op = OP_MTHI; rs = 32'h0000_1234; rt = 32'hDEAD_BEEF;
        seen = 1'b0;
        for (int k = 1; k <= 100 && !seen; k++) begin
            if (k > 1) @(negedge clk);
            if (done) begin
                seen = 1'b1;
                check("hold latency", 64'(k), 64'd34);
            end else begin
                check("hold stall", 64'(stall), 64'd1);
            end
        end
        if (!seen) check("hold done seen", 64'd0, 64'd1);
        check("hold mult hi", 64'(hi), 64'h0);
        check("hold mult lo", 64'(lo), 64'd15);
        check("hold no stall in done", 64'(stall), 64'd0);
        @(negedge clk);
        start = 1'b0;
        check("hold mthi hi", 64'(hi), 64'h1234);
        check("hold mthi lo kept", 64'(lo), 64'd15);
        check("hold mthi no busy", 64'(busy), 64'd0);

        // Reset in CALC cycle 10 abandons the operation
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; rs = 32'h0000_FFFF; rt = 32'h0000_1234;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre-reset busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid reset busy", 64'(busy), 64'd0);
        check("mid reset done", 64'(done), 64'd0);
        check("mid reset hi", 64'(hi), 64'd0);
        check("mid reset lo", 64'(lo), 64'd0);
        dcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check("mid reset no done", 64'(dcnt), 64'd0);
        run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 34, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
